// File: rtl/sum_series_param.sv
// Series-sum engine: Result = sum of term(k) for k=1..N, with term k, k*k or 2k-1 chosen by Mode; saturating build under SUM_SERIES_SAT_EN.
// Latency N+1 edges from Start to Stop; Start is ignored while Busy, and the result holds in DONE until the next Start.
module sum_series_param #(
  parameter int N_W = 8,
  parameter int R_W = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic [N_W-1:0] Data_in,
  input  logic [1:0]     Mode,
  output logic           Busy,
  output logic           Stop,
  output logic [R_W-1:0] Result,
  output logic           Ovf
);

  localparam int C_W = N_W + 1;
  localparam int T_W = 2 * (N_W + 1) + 1;
  localparam int S_W = (T_W > R_W + 1) ? T_W : R_W + 1;
  localparam logic [S_W-1:0] R_MAX = (S_W'(1) << R_W) - S_W'(1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N_W-1:0] n_q;
  logic [1:0]     mode_q;
  logic [C_W-1:0] c_q;
  logic [R_W-1:0] result_q;
  logic           ovf_q;
  logic           accept;
  logic           step;
  logic [T_W-1:0] c_ext;
  logic [T_W-1:0] term;
  logic [S_W-1:0] sum;
  logic           over;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept    = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (c_q <= {1'b0, n_q}) step = 1'b1;
        else                    state_nxt = DONE;
      end
      DONE: begin
        if (Start) begin
          accept    = 1'b1;
          state_nxt = ACC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter is one bit wider than N, so the square always fits in T_W bits.
  assign c_ext = T_W'(c_q);

  always_comb begin
    term = c_ext;
    case (mode_q)
      2'd1:    term = c_ext * c_ext;
      2'd2:    term = c_ext + c_ext - T_W'(1);
      default: term = c_ext;
    endcase
  end

  assign sum  = S_W'(result_q) + S_W'(term);
  assign over = (sum > R_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      n_q      <= '0;
      mode_q   <= '0;
      c_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      n_q      <= Data_in;
      mode_q   <= Mode;
      c_q      <= C_W'(1);
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (step) begin
      c_q <= c_q + C_W'(1);
      if (over) ovf_q <= 1'b1;
`ifdef SUM_SERIES_SAT_EN
      result_q <= (over || ovf_q) ? {R_W{1'b1}} : sum[R_W-1:0];
`else
      result_q <= sum[R_W-1:0];
`endif
    end
  end

  assign Busy   = (state == ACC);
  assign Stop   = (state == DONE);
  assign Result = result_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_sum_series_param.sv
// Randomised bench for sum_series_param: per-cycle comparison against a closed-form series model plus literal checks.
module tb_sum_series_param;

  localparam int N_W = 8;
  localparam int R_W = 16;
`ifdef SUM_SERIES_SAT_EN
  localparam logic [63:0] SQ255_RES = 64'd65535;
`else
  localparam logic [63:0] SQ255_RES = 64'd54656;
`endif

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           Start = 1'b0;
  logic [N_W-1:0] Data_in = '0;
  logic [1:0]     Mode = '0;
  logic           Busy;
  logic           Stop;
  logic [R_W-1:0] Result;
  logic           Ovf;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 Clk = ~Clk;

  sum_series_param #(.N_W(N_W), .R_W(R_W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Data_in(Data_in), .Mode(Mode),
    .Busy(Busy), .Stop(Stop), .Result(Result), .Ovf(Ovf)
  );

  // Reference: a run is (N, mode, edges elapsed since acceptance); outputs follow from partial sums.
  typedef enum {M_IDLE, M_ACC, M_DONE} m_phase_t;
  m_phase_t m_phase = M_IDLE;
  int m_n = 0;
  int m_mode = 0;
  int m_k = 0;

  always @(posedge Clk) begin
    if (Rst) begin
      m_phase = M_IDLE; m_n = 0; m_mode = 0; m_k = 0;
    end else if (m_phase != M_ACC && Start) begin
      m_phase = M_ACC; m_n = int'(Data_in); m_mode = int'(Mode); m_k = 0;
    end else if (m_phase == M_ACC) begin
      m_k++;
      if (m_k > m_n) m_phase = M_DONE;
    end
  end

  function automatic longint term_of(input int k, input int mode);
    case (mode)
      1:       return longint'(k) * longint'(k);
      2:       return 2 * longint'(k) - 1;
      default: return longint'(k);
    endcase
  endfunction

  function automatic void model_out(input int n, input int mode, input int k,
                                    output logic [R_W-1:0] r, output logic o);
    longint s = 0;
    longint lim = (longint'(1) << R_W) - 1;
    int last = (k < n) ? k : n;
    for (int j = 1; j <= last; j++) s += term_of(j, mode);
    o = (s > lim);
`ifdef SUM_SERIES_SAT_EN
    r = o ? {R_W{1'b1}} : R_W'(s);
`else
    r = R_W'(s);
`endif
  endfunction

  always @(negedge Clk) begin
    logic [R_W-1:0] er;
    logic eo, eb, es;
    if (chk_en) begin
      model_out(m_n, m_mode, m_k, er, eo);
      eb = (m_phase == M_ACC);
      es = (m_phase == M_DONE);
      n_tests++;
      if ({Busy, Stop, Ovf, Result} !== {eb, es, eo, er}) begin
        n_fail++;
        $display("FAIL cycle @%0t busy/stop/ovf/result got %0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                 $time, Busy, Stop, Ovf, Result, eb, es, eo, er);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Start a run, scramble inputs while it runs, and check latency, Busy width and final values.
  task automatic run(input int n, input int mode, input string name,
                     input logic [63:0] exp_res, input logic [63:0] exp_ovf);
    int edges = 0;
    int busy_cnt = 0;
    @(negedge Clk);
    Start = 1'b1; Data_in = N_W'(n); Mode = 2'(mode);
    @(negedge Clk);
    Start = 1'b0; Data_in = N_W'($urandom); Mode = 2'($urandom);
    check({name, "_stop_low"}, 64'(Stop), 64'd0);
    if (Busy) busy_cnt++;
    while (!Stop && edges < 2000) begin
      @(negedge Clk);
      edges++;
      Data_in = N_W'($urandom); Mode = 2'($urandom);
      if (Busy) busy_cnt++;
    end
    check({name, "_latency"}, 64'(edges), 64'(n + 1));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(n + 1));
    check({name, "_result"}, 64'(Result), exp_res);
    check({name, "_ovf"}, 64'(Ovf), exp_ovf);
  endtask

  initial begin
    logic [R_W-1:0] mr;
    logic mo;
    int n, m, cyc, idle;
    bit did_rst;

    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_result", 64'(Result), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_stop", 64'(Stop), 64'd0);
    check("reset_ovf", 64'(Ovf), 64'd0);
    chk_en = 1'b1;
    Rst = 1'b0;

    model_out(12, 1, 12, mr, mo);
    check("model_sq12", 64'(mr), 64'd650);
    model_out(5, 2, 5, mr, mo);
    check("model_odd5", 64'(mr), 64'd25);
    model_out(255, 1, 255, mr, mo);
    check("model_sq255_res", 64'(mr), SQ255_RES);
    check("model_sq255_ovf", 64'(mo), 64'd1);

    run(4, 0, "n4_lin", 64'd10, 64'd0);
    run(12, 1, "n12_sq", 64'd650, 64'd0);
    run(5, 2, "n5_odd", 64'd25, 64'd0);
    run(9, 3, "n9_rsv", 64'd45, 64'd0);
    run(0, 0, "n0", 64'd0, 64'd0);
    run(255, 0, "n255_lin", 64'd32640, 64'd0);
    run(255, 1, "n255_sq", SQ255_RES, 64'd1);

    // Start during ACC is ignored, then restart straight from DONE.
    @(negedge Clk);
    Start = 1'b1; Data_in = 8'd9; Mode = 2'd0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Start = 1'b1; Data_in = 8'd3;
    @(negedge Clk);
    Start = 1'b0;
    cyc = 0;
    while (!Stop && cyc < 100) begin @(negedge Clk); cyc++; end
    check("ignore_start_result", 64'(Result), 64'd45);
    run(3, 0, "from_done", 64'd6, 64'd0);

    // Reset on the fourth edge after acceptance aborts the run.
    @(negedge Clk);
    Start = 1'b1; Data_in = 8'd12; Mode = 2'd0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_result", 64'(Result), 64'd0);
    check("abort_stop", 64'(Stop), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_ovf", 64'(Ovf), 64'd0);
    run(7, 0, "after_abort", 64'd28, 64'd0);

    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
      m = int'($urandom_range(0, 3));
      @(negedge Clk);
      Start = 1'b1; Data_in = N_W'(n); Mode = 2'(m);
      @(negedge Clk);
      Start = 1'b0;
      cyc = 0;
      did_rst = 1'b0;
      while (!Stop && !did_rst && cyc < 600) begin
        Start = ($urandom_range(0, 7) == 0);
        Data_in = N_W'($urandom); Mode = 2'($urandom);
        if ($urandom_range(0, 149) == 0) Rst = 1'b1;
        @(negedge Clk);
        if (Rst) begin Rst = 1'b0; did_rst = 1'b1; end
        cyc++;
      end
      Start = 1'b0;
      check("rand_run_ends", 64'(Stop | did_rst), 64'd1);
      idle = int'($urandom_range(0, 3));
      repeat (idle) @(negedge Clk);
    end

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
